// File: rtl/ap_ctrl_perf_monitor.sv
// Performance monitor for HLS ap_ctrl handshakes. Each channel tracks
// IDLE/RUN/STALL, measures start-to-done latency and keeps saturating statistics.
module ap_ctrl_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              enable,
    input  logic              clear,
    input  logic              finish,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy,
    output logic              frozen
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q     [NUM_CH];
    state_t            state_d     [NUM_CH];
    logic [CNT_W-1:0]  lat_q       [NUM_CH];
    logic [CNT_W-1:0]  lat_d       [NUM_CH];
    logic [CNT_W-1:0]  start_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  start_cnt_d [NUM_CH];
    logic [CNT_W-1:0]  done_cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  done_cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  stall_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  stall_cnt_d [NUM_CH];
    logic [CNT_W-1:0]  busy_cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  busy_cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  last_lat_q  [NUM_CH];
    logic [CNT_W-1:0]  last_lat_d  [NUM_CH];
    logic [CNT_W-1:0]  max_lat_q   [NUM_CH];
    logic [CNT_W-1:0]  max_lat_d   [NUM_CH];
    logic [CNT_W-1:0]  cap_val     [NUM_CH];
    logic [NUM_CH-1:0] cap_vld;
    logic [NUM_CH-1:0] err_hit;
    logic [NUM_CH-1:0] err_q;
    logic [NUM_CH-1:0] err_d;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;
    logic              frozen_q;
    logic [CNT_W-1:0]  rd_data_q;
    logic [CNT_W-1:0]  rd_data_d;
    logic              upd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Statistics move only while enabled and not frozen; the FSMs always track.
    assign upd = enable && !frozen_q;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cap_vld = '0;
        err_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cap_val[c] = '0;
            case (state_q[c])
                ST_IDLE: begin
                    if (ap_start[c] && ap_done[c]) begin
                        cap_vld[c] = 1'b1;
                    end else if (ap_start[c]) begin
                        state_d[c] = ST_RUN;
                        lat_d[c]   = CNT_ONE;
                    end else if (ap_done[c]) begin
                        err_hit[c] = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ap_done[c]) begin
                        cap_vld[c] = 1'b1;
                        cap_val[c] = lat_q[c];
                        if (!ap_continue[c]) begin
                            state_d[c] = ST_STALL;
                        end else if (ap_start[c]) begin
                            lat_d[c] = CNT_ONE;
                        end else begin
                            state_d[c] = ST_IDLE;
                        end
                    end else begin
                        lat_d[c] = sat_inc(lat_q[c]);
                    end
                end
                ST_STALL: begin
                    if (ap_continue[c] && ap_start[c]) begin
                        state_d[c] = ST_RUN;
                        lat_d[c]   = CNT_ONE;
                    end else if (ap_continue[c]) begin
                        state_d[c] = ST_IDLE;
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start_cnt_d = start_cnt_q;
        done_cnt_d  = done_cnt_q;
        stall_cnt_d = stall_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        last_lat_d  = last_lat_q;
        max_lat_d   = max_lat_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        if (upd) begin
            for (int c = 0; c < NUM_CH; c++) begin
                // ovf marks an increment that was dropped at the ceiling.
                if (ap_start[c] && ap_ready[c]) begin
                    ovf_d[c]       = ovf_d[c] | (start_cnt_q[c] == CNT_MAX);
                    start_cnt_d[c] = sat_inc(start_cnt_q[c]);
                end
                if (ap_done[c] && ap_continue[c]) begin
                    ovf_d[c]      = ovf_d[c] | (done_cnt_q[c] == CNT_MAX);
                    done_cnt_d[c] = sat_inc(done_cnt_q[c]);
                end
                if (state_q[c] == ST_STALL) begin
                    ovf_d[c]       = ovf_d[c] | (stall_cnt_q[c] == CNT_MAX);
                    stall_cnt_d[c] = sat_inc(stall_cnt_q[c]);
                end
                if (state_q[c] != ST_IDLE) begin
                    ovf_d[c]      = ovf_d[c] | (busy_cnt_q[c] == CNT_MAX);
                    busy_cnt_d[c] = sat_inc(busy_cnt_q[c]);
                end
                if (cap_vld[c]) begin
                    last_lat_d[c] = cap_val[c];
                    if (cap_val[c] > max_lat_q[c]) begin
                        max_lat_d[c] = cap_val[c];
                    end
                end
                if (err_hit[c]) begin
                    err_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (int'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                3'd0:    rd_data_d = start_cnt_q[rd_ch];
                3'd1:    rd_data_d = done_cnt_q[rd_ch];
                3'd2:    rd_data_d = last_lat_q[rd_ch];
                3'd3:    rd_data_d = max_lat_q[rd_ch];
                3'd4:    rd_data_d = stall_cnt_q[rd_ch];
                3'd5:    rd_data_d = busy_cnt_q[rd_ch];
                3'd6:    rd_data_d[3:0] = {state_q[rd_ch], ovf_q[rd_ch], err_q[rd_ch]};
                default: rd_data_d = '0;
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            busy[c] = (state_q[c] != ST_IDLE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]     <= ST_IDLE;
                lat_q[c]       <= '0;
                start_cnt_q[c] <= '0;
                done_cnt_q[c]  <= '0;
                stall_cnt_q[c] <= '0;
                busy_cnt_q[c]  <= '0;
                last_lat_q[c]  <= '0;
                max_lat_q[c]   <= '0;
            end
            err_q    <= '0;
            ovf_q    <= '0;
            frozen_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]     <= state_d[c];
                lat_q[c]       <= lat_d[c];
                start_cnt_q[c] <= start_cnt_d[c];
                done_cnt_q[c]  <= done_cnt_d[c];
                stall_cnt_q[c] <= stall_cnt_d[c];
                busy_cnt_q[c]  <= busy_cnt_d[c];
                last_lat_q[c]  <= last_lat_d[c];
                max_lat_q[c]   <= max_lat_d[c];
            end
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            frozen_q <= frozen_q | finish;
        end
        // Readout samples the pre-edge statistics, even on a clear edge.
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign frozen  = frozen_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Bench for ap_ctrl_perf_monitor: table-driven and hand sequences for the corner
// cases, then randomized traffic against a timestamp-based reference model.
module tb_ap_ctrl_perf_monitor;
    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 3;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
    logic              enable, clear, finish;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] busy;
    logic              frozen;

    ap_ctrl_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .enable(enable), .clear(clear), .finish(finish),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .frozen(frozen)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phases 0 idle / 1 running / 2 waiting for continue,
    // latency from the cycle stamp of the accepted start, unbounded true counts.
    int m_phase  [NUM_CH];
    int m_tstart [NUM_CH];
    int m_start  [NUM_CH];
    int m_done   [NUM_CH];
    int m_stall  [NUM_CH];
    int m_busy   [NUM_CH];
    int m_last   [NUM_CH];
    int m_max    [NUM_CH];
    bit m_err    [NUM_CH];
    bit m_frozen;
    int cyc = 0;
    logic [CNT_W-1:0] exp_q[$];
    bit chk_model = 1'b0;

    typedef struct {
        logic       st;
        logic       dn;
        logic       cont;
        logic [2:0] sel;
        logic       exp_busy;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t tbl [14];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    function automatic logic [CNT_W-1:0] model_read(int ch, int sel);
        bit ovf;
        if (ch >= NUM_CH) return '0;
        ovf = (m_start[ch] > MAXV) || (m_done[ch] > MAXV) ||
              (m_stall[ch] > MAXV) || (m_busy[ch] > MAXV);
        case (sel)
            0: return CNT_W'(clampv(m_start[ch]));
            1: return CNT_W'(clampv(m_done[ch]));
            2: return CNT_W'(m_last[ch]);
            3: return CNT_W'(m_max[ch]);
            4: return CNT_W'(clampv(m_stall[ch]));
            5: return CNT_W'(clampv(m_busy[ch]));
            6: return CNT_W'({m_phase[ch][1:0], ovf, m_err[ch]});
            default: return '0;
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] model_busy();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = (m_phase[c] != 0);
        return v;
    endfunction

    task automatic model_zero();
        for (int c = 0; c < NUM_CH; c++) begin
            m_phase[c] = 0; m_tstart[c] = 0; m_start[c] = 0; m_done[c] = 0;
            m_stall[c] = 0; m_busy[c] = 0; m_last[c] = 0; m_max[c] = 0; m_err[c] = 0;
        end
        m_frozen = 0;
    endtask

    task automatic model_step();
        logic [CNT_W-1:0] e;
        bit upd;
        e = model_read(int'(rd_ch), int'(rd_sel));
        if (reset) begin
            model_zero();
            e = '0;
        end else if (clear) begin
            model_zero();
        end else begin
            upd = enable && !m_frozen;
            for (int c = 0; c < NUM_CH; c++) begin
                bit s, r, d, k, cap, errset;
                int lat;
                s = ap_start[c]; r = ap_ready[c]; d = ap_done[c]; k = ap_continue[c];
                cap = 0; errset = 0; lat = 0;
                if (upd) begin
                    if (s && r) m_start[c]++;
                    if (d && k) m_done[c]++;
                    if (m_phase[c] == 2) m_stall[c]++;
                    if (m_phase[c] != 0) m_busy[c]++;
                end
                if (m_phase[c] == 0) begin
                    if (s && d) cap = 1;
                    else if (s) begin m_phase[c] = 1; m_tstart[c] = cyc; end
                    else if (d) errset = 1;
                end else if (m_phase[c] == 1) begin
                    if (d) begin
                        cap = 1;
                        lat = cyc - m_tstart[c];
                        if (!k) m_phase[c] = 2;
                        else if (s) m_tstart[c] = cyc;
                        else m_phase[c] = 0;
                    end
                end else begin
                    if (k && s) begin m_phase[c] = 1; m_tstart[c] = cyc; end
                    else if (k) m_phase[c] = 0;
                end
                if (upd && cap) begin
                    m_last[c] = clampv(lat);
                    if (m_last[c] > m_max[c]) m_max[c] = m_last[c];
                end
                if (upd && errset) m_err[c] = 1;
            end
            if (finish) m_frozen = 1;
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic tick();
        logic [CNT_W-1:0] e;
        model_step();
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        if (chk_model) begin
            check("rand_rd_data", 32'(rd_data), 32'(e));
            check("rand_busy", 32'(busy), 32'(model_busy()));
            check("rand_frozen", 32'(frozen), 32'(m_frozen));
        end
    endtask

    task automatic idle_inputs();
        ap_start = '0; ap_ready = '1; ap_done = '0; ap_continue = '1;
    endtask

    task automatic do_reset();
        idle_inputs();
        clear = 0; finish = 0; enable = 1; reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic read_check(string name, int ch, int sel, int exp);
        rd_ch = CH_W'(ch); rd_sel = 3'(sel);
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        model_zero();
        idle_inputs();
        enable = 1; clear = 0; finish = 0; rd_ch = '0; rd_sel = '0; reset = 1;
        tick(); tick();
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frozen", 32'(frozen), 32'd0);
        reset = 0;

        // Channel 0 single transaction, start then done five cycles later.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'd1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 8'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 8'd4};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'd5};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'd5};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'd5};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 8'd0};
        rd_ch = '0;
        for (int i = 0; i < 14; i++) begin
            ap_start[0] = tbl[i].st; ap_done[0] = tbl[i].dn;
            ap_continue[0] = tbl[i].cont; rd_sel = tbl[i].sel;
            tick();
            check($sformatf("tbl%0d_busy0", i), 32'(busy[0]), 32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].exp_rd));
        end

        // Channel 1: done held with continue low for three cycles.
        do_reset();
        rd_ch = 3'd1; rd_sel = 3'd0;
        ap_start[1] = 1; tick(); ap_start[1] = 0;
        tick(); tick();
        ap_done[1] = 1; ap_continue[1] = 0; tick();
        check("stall_busy1", 32'(busy[1]), 32'd1);
        rd_sel = 3'd6;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ap_continue[1] = 1;
            tick();
            check($sformatf("stall_flags%0d", i), 32'(rd_data), 32'd8);
        end
        ap_done[1] = 0;
        check("stall_exit_busy1", 32'(busy[1]), 32'd0);
        read_check("stall_cnt", 1, 4, 3);
        read_check("stall_done_cnt", 1, 1, 1);
        read_check("stall_last_lat", 1, 2, 3);
        read_check("stall_flags_idle", 1, 6, 0);

        // Channel 2: back-to-back transactions of latency 4 then 7.
        do_reset();
        ap_start[2] = 1; tick(); ap_start[2] = 0;
        check("b2b_busy_s", 32'(busy[2]), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("b2b_busy_a%0d", i), 32'(busy[2]), 32'd1);
        end
        ap_done[2] = 1; ap_start[2] = 1; tick(); ap_done[2] = 0; ap_start[2] = 0;
        check("b2b_busy_turn", 32'(busy[2]), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("b2b_busy_b%0d", i), 32'(busy[2]), 32'd1);
        end
        ap_done[2] = 1; tick(); ap_done[2] = 0;
        check("b2b_busy_end", 32'(busy[2]), 32'd0);
        read_check("b2b_last_lat", 2, 2, 7);
        read_check("b2b_max_lat", 2, 3, 7);
        read_check("b2b_start_cnt", 2, 0, 2);
        read_check("b2b_done_cnt", 2, 1, 2);

        // Channel 3 held in RUN long enough to saturate, then cleared.
        do_reset();
        ap_start[3] = 1; tick(); ap_start[3] = 0;
        repeat (300) tick();
        read_check("sat_busy_cnt", 3, 5, MAXV);
        read_check("sat_flags", 3, 6, 6);
        ap_done[3] = 1; tick(); ap_done[3] = 0;
        read_check("sat_last_lat", 3, 2, MAXV);
        clear = 1; tick(); clear = 0;
        check("clr_busy", 32'(busy), 32'd0);
        read_check("clr_busy_cnt", 3, 5, 0);
        read_check("clr_flags", 3, 6, 0);
        read_check("clr_last_lat", 3, 2, 0);

        // Stray done while idle, then finish freezes the statistics.
        do_reset();
        ap_done[0] = 1; ap_continue[0] = 0; tick();
        ap_done[0] = 0; ap_continue[0] = 1;
        read_check("err_flag", 0, 6, 1);
        read_check("err_done_cnt", 0, 1, 0);
        read_check("err_start_cnt", 0, 0, 0);
        check("pre_finish_frozen", 32'(frozen), 32'd0);
        finish = 1; tick(); finish = 0;
        check("finish_frozen", 32'(frozen), 32'd1);
        ap_start[0] = 1; tick(); ap_start[0] = 0;
        check("frz_busy0", 32'(busy[0]), 32'd1);
        tick(); tick();
        ap_done[0] = 1; tick(); ap_done[0] = 0;
        read_check("frz_start_cnt", 0, 0, 0);
        read_check("frz_done_cnt", 0, 1, 0);
        read_check("frz_last_lat", 0, 2, 0);
        read_check("frz_busy_cnt", 0, 5, 0);
        check("frz_hold", 32'(frozen), 32'd1);
        clear = 1; tick(); clear = 0;
        check("clr_frozen", 32'(frozen), 32'd0);
        read_check("clr_err_flag", 0, 6, 0);

        // Out-of-range channel readout and reset in the middle of a run.
        do_reset();
        ap_start[0] = 1; rd_ch = 3'd5; rd_sel = 3'd0; tick(); ap_start[0] = 0;
        read_check("oob_ch5", 5, 0, 0);
        read_check("inrange_ch0", 0, 0, 1);
        read_check("oob_ch7", 7, 0, 0);
        reset = 1; tick();
        check("midrun_reset_busy", 32'(busy), 32'd0);
        check("midrun_reset_rd", 32'(rd_data), 32'd0);
        reset = 0;
        for (int s = 0; s < 7; s++) read_check($sformatf("post_reset_sel%0d", s), 0, s, 0);

        // Randomized traffic against the model.
        do_reset();
        chk_model = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ap_start[c]    = ($urandom_range(0, 3) == 0);
                ap_ready[c]    = ($urandom_range(0, 1) == 1);
                ap_done[c]     = ($urandom_range(0, 4) == 0);
                ap_continue[c] = ($urandom_range(0, 3) != 0);
            end
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 99) == 0);
            finish = ($urandom_range(0, 199) == 0);
            reset  = ($urandom_range(0, 299) == 0);
            rd_ch  = CH_W'($urandom_range(0, 7));
            rd_sel = 3'($urandom_range(0, 7));
            tick();
        end
        chk_model = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
